button_event_decoder: RTL and testbench

BUTTON_EVENT_DECODER -- requirements
Module: button_event_decoder

---
 rtl/button_event_decoder.sv | 162 ++++++++++++++++
 tb/tb_button_event_decoder.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/button_event_decoder.sv
// button_event_decoder: classifies a debounced switch into press/release/short/long/double events.
// Ports:
//   i_clk     - sole clock, rising edge
//   i_rst_n   - asynchronous active-low reset
//   i_sw      - debounced switch level, 1 = pressed
//   o_press   - one-cycle pulse per accepted press edge
//   o_release - one-cycle pulse per accepted release edge
//   o_short   - one-cycle pulse when a single short click is classified
//   o_long    - one-cycle pulse when a press reaches LONG_PRESS_COUNT samples
//   o_double  - one-cycle pulse when a double click is classified (0 unless enabled)
//   o_held    - level, high while a long press is held
// Define BUTTON_DOUBLE_CLICK_EN to enable double-click detection; without it a
// short release reports o_short together with o_release.
module button_event_decoder #(
    parameter int LONG_PRESS_COUNT = 12500000,
    parameter int DOUBLE_GAP_COUNT = 6250000
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_sw,
    output logic o_press,
    output logic o_release,
    output logic o_short,
    output logic o_long,
    output logic o_double,
    output logic o_held
);
    if (LONG_PRESS_COUNT < 1 || LONG_PRESS_COUNT > 16777215) begin : g_bad_long
        $error("LONG_PRESS_COUNT must be in 1..16777215");
    end
    if (DOUBLE_GAP_COUNT < 1 || DOUBLE_GAP_COUNT > 16777215) begin : g_bad_gap
        $error("DOUBLE_GAP_COUNT must be in 1..16777215");
    end

    localparam logic [23:0] C_LONG = 24'(LONG_PRESS_COUNT);
    localparam bit C_LONG_ONE = (LONG_PRESS_COUNT == 1);
`ifdef BUTTON_DOUBLE_CLICK_EN
    localparam logic [23:0] C_GAP = 24'(DOUBLE_GAP_COUNT);
`endif

    typedef enum logic [2:0] {
        IDLE,
        PRESSED,
        LONG_HELD
`ifdef BUTTON_DOUBLE_CLICK_EN
        ,
        WAIT_SECOND,
        SECOND_PRESSED
`endif
    } state_t;

    state_t      r_state;
    logic        r_sw_d;
    logic [23:0] r_cnt;
    logic        r_press;
    logic        r_release;
    logic        r_short;
    logic        r_long;
    logic        r_double;
    logic        r_held;
    logic        w_rise;
    logic        w_long_hit;

    assign w_rise     = i_sw & ~r_sw_d;
    // r_cnt holds the high samples seen so far; the current high sample makes it one more
    assign w_long_hit = (r_cnt + 24'd1) == C_LONG;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_sw_d    <= 1'b1;
            r_press   <= 1'b0;
            r_release <= 1'b0;
            r_short   <= 1'b0;
            r_long    <= 1'b0;
            r_double  <= 1'b0;
            r_held    <= 1'b0;
        end else begin
            r_sw_d    <= i_sw;
            r_press   <= 1'b0;
            r_release <= 1'b0;
            r_short   <= 1'b0;
            r_long    <= 1'b0;
            r_double  <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_rise) begin
                        r_press <= 1'b1;
                        r_cnt   <= 24'd1;
                        r_long  <= C_LONG_ONE;
                        r_held  <= C_LONG_ONE;
                        r_state <= C_LONG_ONE ? LONG_HELD : PRESSED;
                    end
                end
                PRESSED: begin
                    if (!i_sw) begin
                        r_release <= 1'b1;
`ifdef BUTTON_DOUBLE_CLICK_EN
                        r_cnt     <= 24'd1;
                        r_state   <= WAIT_SECOND;
`else
                        r_short   <= 1'b1;
                        r_state   <= IDLE;
`endif
                    end else if (w_long_hit) begin
                        r_long  <= 1'b1;
                        r_held  <= 1'b1;
                        r_state <= LONG_HELD;
                    end else begin
                        r_cnt <= r_cnt + 24'd1;
                    end
                end
                LONG_HELD: begin
                    if (!i_sw) begin
                        r_release <= 1'b1;
                        r_held    <= 1'b0;
                        r_state   <= IDLE;
                    end
                end
`ifdef BUTTON_DOUBLE_CLICK_EN
                WAIT_SECOND: begin
                    // a rise on the same edge as the gap limit still counts as the second click
                    if (w_rise) begin
                        r_press <= 1'b1;
                        r_cnt   <= 24'd1;
                        r_long  <= C_LONG_ONE;
                        r_held  <= C_LONG_ONE;
                        r_state <= C_LONG_ONE ? LONG_HELD : SECOND_PRESSED;
                    end else if (r_cnt == C_GAP) begin
                        r_short <= 1'b1;
                        r_state <= IDLE;
                    end else begin
                        r_cnt <= r_cnt + 24'd1;
                    end
                end
                SECOND_PRESSED: begin
                    if (!i_sw) begin
                        r_release <= 1'b1;
                        r_double  <= 1'b1;
                        r_state   <= IDLE;
                    end else if (w_long_hit) begin
                        r_long  <= 1'b1;
                        r_held  <= 1'b1;
                        r_state <= LONG_HELD;
                    end else begin
                        r_cnt <= r_cnt + 24'd1;
                    end
                end
`endif
                default: r_state <= IDLE;
            endcase
        end
    end

    assign o_press   = r_press;
    assign o_release = r_release;
    assign o_short   = r_short;
    assign o_long    = r_long;
    assign o_double  = r_double;
    assign o_held    = r_held;
endmodule

// File: tb/tb_button_event_decoder.sv
// tb_button_event_decoder: directed scenarios checked every cycle against a run-length model.
module tb_button_event_decoder;
    localparam int LONG = 20;
    localparam int GAP  = 10;
`ifdef BUTTON_DOUBLE_CLICK_EN
    localparam bit DBL = 1'b1;
`else
    localparam bit DBL = 1'b0;
`endif

    logic i_clk;
    logic i_rst_n;
    logic i_sw;
    logic o_press, o_release, o_short, o_long, o_double, o_held;

    button_event_decoder #(.LONG_PRESS_COUNT(LONG), .DOUBLE_GAP_COUNT(GAP)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_sw(i_sw),
        .o_press(o_press), .o_release(o_release), .o_short(o_short),
        .o_long(o_long), .o_double(o_double), .o_held(o_held)
    );

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    // Model: counts high samples of the tracked press and low samples after a short click.
    // exp bits: {press, release, short, long, double, held}
    bit       m_prev;
    int       m_hi;
    int       m_lo;
    bit       m_long;
    bit       m_pend;
    logic [5:0] exp_o;

    always @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            m_prev <= 1'b1;
            m_hi   <= 0;
            m_lo   <= 0;
            m_long <= 1'b0;
            m_pend <= 1'b0;
            exp_o  <= '0;
        end else begin : step_model
            bit s, lg, pd, pr, rl, sh, ln, db;
            int hi, lo;
            s = i_sw; hi = m_hi; lo = m_lo; lg = m_long; pd = m_pend;
            pr = 0; rl = 0; sh = 0; ln = 0; db = 0;
            if (s && !m_prev) begin
                pr = 1; hi = 1; lg = 0;
            end else if (s && hi > 0 && !lg) begin
                hi = hi + 1;
            end
            if (s && hi > 0 && !lg && hi == LONG) begin
                lg = 1; ln = 1; pd = 0;
            end
            if (!s && m_prev && hi > 0) begin
                rl = 1;
                if (!lg) begin
                    if (pd) begin
                        db = 1; pd = 0;
                    end else if (DBL) begin
                        pd = 1; lo = 0;
                    end else begin
                        sh = 1;
                    end
                end
                hi = 0; lg = 0;
            end
            if (!s && pd) begin
                lo = lo + 1;
                if (lo > GAP) begin
                    sh = 1; pd = 0;
                end
            end
            m_prev <= s;
            m_hi   <= hi;
            m_lo   <= lo;
            m_long <= lg;
            m_pend <= pd;
            exp_o  <= {pr, rl, sh, ln, db, lg && hi > 0};
        end
    end

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int n[6];
    int t[6];
    int base[6];

    task automatic chk(input string nm, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s cycle=%0d got=%0d want=%0d", nm, cyc, got, want);
        end
    endtask

    task automatic step(input logic sw, input logic rst_n);
        logic [5:0] got;
        i_sw = sw;
        i_rst_n = rst_n;
        @(negedge i_clk);
        cyc++;
        got = {o_press, o_release, o_short, o_long, o_double, o_held};
        chk("outputs_vs_model", int'(got), int'(exp_o));
        chk("short_long_double_onehot", int'($countones({o_short, o_long, o_double}) <= 1), 1);
        for (int i = 0; i < 6; i++) begin
            if (got[5-i]) begin
                n[i]++;
                t[i] = cyc;
            end
        end
    endtask

    task automatic run(input logic sw, input int len);
        for (int i = 0; i < len; i++) step(sw, 1'b1);
    endtask

    task automatic mark();
        for (int i = 0; i < 6; i++) base[i] = n[i];
    endtask

    // idx: 0 press, 1 release, 2 short, 3 long, 4 double, 5 held cycles
    task automatic pin(input string nm, input int idx, input int want);
        chk(nm, n[idx] - base[idx], want);
    endtask

    task automatic click2(input int h1, input int l1, input int h2, input int l2);
        mark();
        run(1'b1, h1);
        run(1'b0, l1);
        run(1'b1, h2);
        run(1'b0, l2);
    endtask

    initial begin
        for (int i = 0; i < 6; i++) begin
            n[i] = 0; t[i] = 0; base[i] = 0;
        end
        i_sw = 1'b0;
        i_rst_n = 1'b0;
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0);
        chk("reset_outputs_zero", int'({o_press, o_release, o_short, o_long, o_double, o_held}), 0);
        run(1'b0, 3);

        // short click
        mark();
        run(1'b1, 5);
        run(1'b0, 15);
        pin("short_press", 0, 1);
        pin("short_release", 1, 1);
        pin("short_short", 2, 1);
        pin("short_long", 3, 0);
        chk("short_delay", t[2] - t[1], DBL ? GAP : 0);

        // long press held 30 samples
        mark();
        run(1'b1, 30);
        run(1'b0, 12);
        pin("long_press", 0, 1);
        pin("long_long", 3, 1);
        pin("long_release", 1, 1);
        pin("long_short", 2, 0);
        pin("long_held_cycles", 5, 11);
        chk("long_delay", t[3] - t[0], LONG - 1);
        chk("long_release_delay", t[1] - t[0], 30);

        // two short clicks, gap 4
        click2(5, 4, 5, 12);
        pin("dbl_press", 0, 2);
        pin("dbl_release", 1, 2);
        pin("dbl_double", 4, DBL ? 1 : 0);
        pin("dbl_short", 2, DBL ? 0 : 2);
        if (DBL) chk("dbl_with_release", t[4], t[1]);

        // short click then long second press
        click2(5, 4, 25, 12);
        pin("sl_long", 3, 1);
        pin("sl_double", 4, 0);
        pin("sl_short", 2, DBL ? 0 : 1);

        // gap of exactly GAP low samples is still a double click
        click2(5, GAP, 5, 12);
        pin("gap_eq_double", 4, DBL ? 1 : 0);
        pin("gap_eq_short", 2, DBL ? 0 : 2);

        // one more low sample times the first click out
        click2(5, GAP + 1, 5, 12);
        pin("gap_over_double", 4, 0);
        pin("gap_over_short", 2, 2);
        pin("gap_over_press", 0, 2);

        // 19 high samples is short, 20 is long
        mark();
        run(1'b1, LONG - 1);
        run(1'b0, 12);
        pin("th_minus_long", 3, 0);
        pin("th_minus_short", 2, 1);
        mark();
        run(1'b1, LONG);
        run(1'b0, 12);
        pin("th_exact_long", 3, 1);
        pin("th_exact_short", 2, 0);
        pin("th_exact_held", 5, 1);

        // reset during a press with the switch held through reset release
        run(1'b1, 8);
        mark();
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0);
        run(1'b1, 10);
        pin("rst_press", 0, 0);
        pin("rst_release", 1, 0);
        pin("rst_long", 3, 0);
        pin("rst_held", 5, 0);
        run(1'b0, 3);
        pin("rst_fall_ignored", 1, 0);
        mark();
        run(1'b1, 5);
        run(1'b0, 12);
        pin("rst_repress", 0, 1);
        pin("rst_repress_short", 2, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
